// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Optional round-robin arbitration is enabled with MEM_ARB_RR_EN.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_DATA_W = 32;

  localparam logic PORT_DATA = 1'b0;
  localparam logic PORT_AUX  = 1'b1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  // Word aligned and inside the addressable window.
  function automatic logic addr_legal(input logic [31:0] addr, input int unsigned addr_w);
    return (addr[1:0] == 2'b00) && ((addr >> (addr_w + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the two requesters.
// Fixed priority (port 0 first) by default; round-robin when MEM_ARB_RR_EN is defined.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic id
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      id = ~last;
    end else begin
      id = req1 ? PORT_AUX : PORT_DATA;
    end
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    valid = req0 | req1;
    id    = req0 ? PORT_DATA : PORT_AUX;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sequencing accesses to a single-ported, fixed-latency data memory.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, id_q, last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              m0_ack_q, m0_err_q, m1_ack_q, m1_err_q;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

  logic              pick_valid, pick_id, pick_we, legal;
  logic [31:0]       pick_addr;
  logic [DATA_W-1:0] pick_wdata;

  mem_arb_pick u_pick (
    .req0  (m0_req),
    .req1  (m1_req),
    .last  (last_q),
    .valid (pick_valid),
    .id    (pick_id)
  );

  always_comb begin
    pick_we    = pick_id ? m1_we    : m0_we;
    pick_addr  = pick_id ? m1_addr  : m0_addr;
    pick_wdata = pick_id ? m1_wdata : m0_wdata;
    legal      = addr_legal(pick_addr, ADDR_W);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) state_d = legal ? ST_ISSUE : ST_RESP;
      end
      ST_ISSUE: begin
        if (WAIT_STATES > 0) begin
          state_d = ST_WAIT;
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WS_LAST) state_d = ST_DONE;
        else                  cnt_d   = cnt_q + 4'd1;
      end
      ST_DONE: state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      id_q       <= 1'b0;
      last_q     <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      m0_ack_q   <= 1'b0;
      m0_err_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_ack_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      m1_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      if (state_q == ST_IDLE && pick_valid) begin
        id_q    <= pick_id;
        last_q  <= pick_id;
        we_q    <= pick_we;
        addr_q  <= pick_addr[ADDR_W+1:2];
        wdata_q <= pick_wdata;
        // Illegal access skips the memory and answers straight from IDLE.
        if (!legal) begin
          if (pick_id) begin
            m1_ack_q   <= 1'b1;
            m1_err_q   <= 1'b1;
            m1_rdata_q <= '0;
          end else begin
            m0_ack_q   <= 1'b1;
            m0_err_q   <= 1'b1;
            m0_rdata_q <= '0;
          end
        end
      end
      if (state_q == ST_DONE) begin
        if (id_q) begin
          m1_ack_q   <= 1'b1;
          m1_err_q   <= 1'b0;
          m1_rdata_q <= we_q ? '0 : mem_rdata;
        end else begin
          m0_ack_q   <= 1'b1;
          m0_err_q   <= 1'b0;
          m0_rdata_q <= we_q ? '0 : mem_rdata;
        end
      end
    end
  end

  assign mem_en    = (state_q == ST_ISSUE);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign grant_id  = id_q;
  assign m0_ack    = m0_ack_q;
  assign m0_err    = m0_err_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_ack    = m1_ack_q;
  assign m1_err    = m1_err_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported data memory between two requesters: port 0 (load/store stage) and port 1 (secondary master: instruction-fetch refill or debug loader).
- Sequences each access through a fixed-latency memory protocol with configurable wait states.
- Returns read data with a one-cycle ack.
- Sits between the pipeline's memory stage and the word-addressed 1024-entry data memory.

Parameters:
ADDR_W, 10, word-address width of memory (1024 words)
DATA_W, 32, data word width
WAIT_STATES, 0, extra memory read latency beyond 1 cycle (0..15)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
m0_req  in  1  port 0 request; held with fields stable until m0_ack
m0_we  in  1  port 0 write (1) / read (0)
m0_addr  in  32  port 0 byte address
m0_wdata  in  DATA_W  port 0 write data
m0_ack  out  1  port 0 completion pulse (one cycle)
m0_err  out  1  port 0 address error, valid with m0_ack
m0_rdata  out  DATA_W  port 0 read data, valid with m0_ack
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same as port 0, for port 1
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  word address = granted addr[ADDR_W+1:2]
mem_wdata  out  DATA_W  granted write data
mem_rdata  in  DATA_W  memory read data, valid WAIT_STATES+1 cycles after mem_en cycle
busy  out  1  high in every state except IDLE
grant_id  out  1  port currently or most recently granted

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; grant_id=0; wait counter 0.
- Reset mid-access: access is abandoned, no ack is issued, and the memory write is not retried.
- FSM: IDLE, ISSUE, WAIT, DONE, RESP.
- IDLE:
  - If any req is high, select a winner, latch its we/addr/wdata and its id.
  - Address check: the access is legal iff addr[1:0]==0 and addr[31:ADDR_W+2]==0.
  - Legal access goes to ISSUE. Illegal access goes directly to RESP with err=1, rdata=0, and no memory access.
- ISSUE:
  - mem_en=1 and mem_we=latched we for exactly this cycle.
  - Next state is WAIT if WAIT_STATES>0, else DONE.
- WAIT: counter counts WAIT_STATES cycles, then goes to DONE.
- DONE:
  - For a read, mem_rdata is sampled into the winner's rdata register at the edge ending DONE.
  - For a write, the winner's rdata is set to 0.
  - Next state is RESP.
- RESP:
  - Winner's ack=1, registered, for exactly one cycle. The other port's ack/rdata are unchanged (ack=0).
  - Next state is IDLE.
- Latency, legal access: req sampled in IDLE cycle N, ack visible in cycle N+3+WAIT_STATES.
- Latency, illegal access: ack visible in cycle N+1.
- Back-to-back throughput: one access per 4+WAIT_STATES cycles.
- Arbitration, default: fixed priority, port 0 over port 1.
  - Simultaneous req: port 0 wins; port 1 is served on the next IDLE if port 0 is not requesting then.
- Committed grant: once latched, the access completes even if req drops (requester protocol violation). The arbiter ignores the dropped req afterwards.
- A req that is still high during RESP is not sampled. The requester must drop req in the cycle after ack or a new access starts.
- grant_id holds its value in IDLE.
- busy = (state != IDLE).

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A last-winner bit is updated on entry to ISSUE or RESP.
  - On simultaneous req, the port that did not win last time wins.
  - Last-winner resets to 1, so port 0 wins the first tie.
- Undefined: fixed priority, port 0 over port 1, as above.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, DONE, RESP)
  - requester-id constants PORT_DATA=0, PORT_AUX=1
  - default ADDR_W/DATA_W localparams
- Sub-module mem_arb_pick: combinational winner select from the two reqs plus the last-winner bit. It contains both the fixed-priority and RR logic under the macro.

Test Plan:
- Port 0 writes 0xDEADBEEF to byte addr 0x10, then reads 0x10, WAIT_STATES=0 -> mem_en pulse with mem_addr=4; read ack 3 cycles after req with m0_rdata=0xDEADBEEF, m0_err=0.
- m0_req and m1_req both rise in the same cycle, reading addrs 0x0 and 0x4 -> port 0 acked first, port 1 acked 4 cycles later. With MEM_ARB_RR_EN and a repeated tie, winners alternate 0,1,0,1.
- WAIT_STATES=3, port 1 read of 0xFFC -> ack exactly 6 cycles after req; mem_rdata sampled 4 cycles after mem_en.
- Illegal addresses 0x2 and 0x1000 -> m0_ack next cycle with m0_err=1, m0_rdata=0, mem_en never asserted.
- reset asserted during WAIT -> all outputs 0 immediately, state IDLE, no ack; a fresh request after deassertion completes normally.
- m0_req dropped during WAIT -> access still completes with m0_ack pulse; no second access issued.
